// File: rtl/nx_fifo_ctrl_wm.sv
// FIFO pointer/occupancy controller with programmable almost-full/empty thresholds,
// a resettable high watermark and sticky overflow/underflow flags; storage lives elsewhere.
module nx_fifo_ctrl_wm #(
  parameter int DEPTH = 8
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   wen,
  input  logic                                   ren,
  input  logic                                   clear,
  input  logic [$clog2(DEPTH+1)-1:0]             afull_thr,
  input  logic [$clog2(DEPTH+1)-1:0]             aempty_thr,
  input  logic                                   wm_clr,
  input  logic                                   err_clr,
  output logic                                   empty,
  output logic                                   full,
  output logic                                   almost_full,
  output logic                                   almost_empty,
  output logic [$clog2(DEPTH+1)-1:0]             used_slots,
  output logic [$clog2(DEPTH+1)-1:0]             free_slots,
  output logic [((DEPTH > 2) ? $clog2(DEPTH) : 1)-1:0] rptr,
  output logic [((DEPTH > 2) ? $clog2(DEPTH) : 1)-1:0] wptr,
  output logic [$clog2(DEPTH+1)-1:0]             high_wm,
  output logic                                   overflow,
  output logic                                   underflow,
  output logic                                   overflow_sticky,
  output logic                                   underflow_sticky
);

  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

  generate
    if (DEPTH < 2) begin : g_bad_depth
      $error("nx_fifo_ctrl_wm: DEPTH must be at least 2");
    end
  endgenerate

  logic          wr_acc;
  logic          rd_acc;
  logic [CW-1:0] used_next;
  logic [AW-1:0] rptr_next;
  logic [AW-1:0] wptr_next;
  logic [CW-1:0] wm_next;

  assign wr_acc    = wen & ~full & ~clear;
  assign rd_acc    = ren & ~empty & ~clear;
  // Error pulses look only at the registered status, so clear does not mask them.
  assign overflow  = wen & full;
  assign underflow = ren & empty;

  always_comb begin
    used_next = used_slots;
    rptr_next = rptr;
    wptr_next = wptr;
    if (clear) begin
      used_next = '0;
      rptr_next = '0;
      wptr_next = '0;
    end else begin
      if (wr_acc && !rd_acc) used_next = used_slots + CW'(1);
      if (rd_acc && !wr_acc) used_next = used_slots - CW'(1);
      if (rd_acc) rptr_next = (rptr == PTR_LAST) ? '0 : rptr + AW'(1);
      if (wr_acc) wptr_next = (wptr == PTR_LAST) ? '0 : wptr + AW'(1);
    end
    // used_next is 0 under clear, so the max() path leaves the watermark intact.
    if (wm_clr)                    wm_next = used_next;
    else if (used_next > high_wm)  wm_next = used_next;
    else                           wm_next = high_wm;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      empty            <= 1'b1;
      full             <= 1'b0;
      almost_full      <= 1'b0;
      almost_empty     <= 1'b1;
      used_slots       <= '0;
      free_slots       <= DEPTH_C;
      rptr             <= '0;
      wptr             <= '0;
      high_wm          <= '0;
      overflow_sticky  <= 1'b0;
      underflow_sticky <= 1'b0;
    end else begin
      empty            <= (used_next == '0);
      full             <= (used_next == DEPTH_C);
      almost_full      <= (used_next >= afull_thr);
      almost_empty     <= (used_next <= aempty_thr);
      used_slots       <= used_next;
      free_slots       <= DEPTH_C - used_next;
      rptr             <= rptr_next;
      wptr             <= wptr_next;
      high_wm          <= wm_next;
      overflow_sticky  <= overflow | (overflow_sticky & ~err_clr);
      underflow_sticky <= underflow | (underflow_sticky & ~err_clr);
    end
  end

endmodule

// File: tb/tb_nx_fifo_ctrl_wm.sv
// Scoreboard bench for nx_fifo_ctrl_wm at DEPTH=5: directed vectors plus a modelled random phase.
module tb_nx_fifo_ctrl_wm;

  localparam int D = 5;

  logic       clk;
  logic       rst_n;
  logic       wen, ren, clear, wm_clr, err_clr;
  logic [2:0] afull_thr, aempty_thr;
  logic       empty, full, almost_full, almost_empty;
  logic [2:0] used_slots, free_slots, high_wm;
  logic [2:0] rptr, wptr;
  logic       overflow, underflow, overflow_sticky, underflow_sticky;

  nx_fifo_ctrl_wm #(.DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .wen(wen), .ren(ren), .clear(clear),
    .afull_thr(afull_thr), .aempty_thr(aempty_thr), .wm_clr(wm_clr), .err_clr(err_clr),
    .empty(empty), .full(full), .almost_full(almost_full), .almost_empty(almost_empty),
    .used_slots(used_slots), .free_slots(free_slots), .rptr(rptr), .wptr(wptr),
    .high_wm(high_wm), .overflow(overflow), .underflow(underflow),
    .overflow_sticky(overflow_sticky), .underflow_sticky(underflow_sticky)
  );

  typedef struct {
    string nm;
    bit    ovf, unf;
    int    used, rp, wp, hwm;
    bit    os, us;
    int    aft, aet;
  } exp_t;

  exp_t q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  bit   busy    = 0;
  bit   seen_zero = 0;
  bit   seen_full = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, queue=%0d", q.size());
    $fatal(1, "timeout");
  end

  function automatic void chk(string rec, string fld, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s.%s: got %0d, expected %0d", rec, fld, act, exp);
  endfunction

  // Drive one cycle of stimulus and queue the response it must produce.
  task automatic step(input string nm, input bit r_n, input bit w, input bit r, input bit c,
                      input bit wm, input bit ec, input int aft, input int aet,
                      input bit eo, input bit eu, input int used, input int rp, input int wp,
                      input int hwm, input bit os, input bit us);
    exp_t e;
    @(negedge clk);
    rst_n = r_n; wen = w; ren = r; clear = c; wm_clr = wm; err_clr = ec;
    afull_thr = 3'(aft); aempty_thr = 3'(aet);
    e.nm = nm; e.ovf = eo; e.unf = eu; e.used = used; e.rp = rp; e.wp = wp;
    e.hwm = hwm; e.os = os; e.us = us; e.aft = aft; e.aet = aet;
    q.push_back(e);
  endtask

  task automatic ds(input string nm, input bit r_n, input bit w, input bit r, input bit c,
                    input bit wm, input bit ec, input bit eo, input bit eu, input int used,
                    input int rp, input int wp, input int hwm, input bit os, input bit us);
    step(nm, r_n, w, r, c, wm, ec, 4, 1, eo, eu, used, rp, wp, hwm, os, us);
  endtask

  // Monitor: error pulses are checked before the edge, registered state just after it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (q.size() != 0) begin
        busy = 1;
        e = q.pop_front();
        chk(e.nm, "overflow",  int'(overflow),  int'(e.ovf));
        chk(e.nm, "underflow", int'(underflow), int'(e.unf));
        @(posedge clk);
        #1;
        chk(e.nm, "used_slots",   int'(used_slots),   e.used);
        chk(e.nm, "free_slots",   int'(free_slots),   D - e.used);
        chk(e.nm, "empty",        int'(empty),        int'(e.used == 0));
        chk(e.nm, "full",         int'(full),         int'(e.used == D));
        chk(e.nm, "almost_full",  int'(almost_full),  int'(e.used >= e.aft));
        chk(e.nm, "almost_empty", int'(almost_empty), int'(e.used <= e.aet));
        chk(e.nm, "rptr",         int'(rptr),         e.rp);
        chk(e.nm, "wptr",         int'(wptr),         e.wp);
        chk(e.nm, "high_wm",      int'(high_wm),      e.hwm);
        chk(e.nm, "ovf_sticky",   int'(overflow_sticky),  int'(e.os));
        chk(e.nm, "unf_sticky",   int'(underflow_sticky), int'(e.us));
        chk(e.nm, "ptr_invariant", (int'(wptr) - int'(rptr) + D) % D, int'(used_slots) % D);
        if (used_slots == 3'd0) seen_zero = 1;
        if (used_slots == 3'(D)) seen_full = 1;
        busy = 0;
      end
    end
  end

  initial begin
    int  mu, mr, mw, mh;
    bit  mo, mun;
    rst_n = 1'b0; wen = 0; ren = 0; clear = 0; wm_clr = 0; err_clr = 0;
    afull_thr = 3'd4; aempty_thr = 3'd1;

    //     name           rst w r c wm ec  eo eu used rp wp hwm os us
    ds("rst_hold",        0, 0,0,0,0,0,   0,0,  0, 0,0, 0,  0,0);
    ds("rd_empty",        1, 0,1,0,0,0,   0,1,  0, 0,0, 0,  0,1);
    ds("wr1",             1, 1,0,0,0,0,   0,0,  1, 0,1, 1,  0,1);
    ds("wr2",             1, 1,0,0,0,0,   0,0,  2, 0,2, 2,  0,1);
    ds("rst_mid_burst",   0, 1,0,0,0,0,   0,0,  0, 0,0, 0,  0,0);
    ds("resume_wr1",      1, 1,0,0,0,0,   0,0,  1, 0,1, 1,  0,0);
    ds("wr2_ae_drop",     1, 1,0,0,0,0,   0,0,  2, 0,2, 2,  0,0);
    ds("wr3",             1, 1,0,0,0,0,   0,0,  3, 0,3, 3,  0,0);
    ds("wr4_af_rise",     1, 1,0,0,0,0,   0,0,  4, 0,4, 4,  0,0);
    ds("wr5_full_wrap",   1, 1,0,0,0,0,   0,0,  5, 0,0, 5,  0,0);
    ds("wr6_overflow",    1, 1,0,0,0,0,   1,0,  5, 0,0, 5,  1,0);
    ds("full_wr_rd",      1, 1,1,0,0,0,   1,0,  4, 1,0, 5,  1,0);
    ds("rd_to3",          1, 0,1,0,0,0,   0,0,  3, 2,0, 5,  1,0);
    ds("wm_clr_at3",      1, 0,0,0,1,0,   0,0,  3, 2,0, 3,  1,0);
    ds("clear_with_wen",  1, 1,0,1,0,0,   0,0,  0, 0,0, 3,  1,0);
    ds("wm_clr_at0",      1, 0,0,0,1,0,   0,0,  0, 0,0, 0,  1,0);
    ds("err_clr",         1, 0,0,0,0,1,   0,0,  0, 0,0, 0,  0,0);
    ds("rd_empty2",       1, 0,1,0,0,0,   0,1,  0, 0,0, 0,  0,1);
    ds("empty_wr_rd",     1, 1,1,0,0,0,   0,1,  1, 0,1, 1,  0,1);
    ds("err_clr2",        1, 0,0,0,0,1,   0,0,  1, 0,1, 1,  0,0);
    ds("fill2",           1, 1,0,0,0,0,   0,0,  2, 0,2, 2,  0,0);
    ds("fill3",           1, 1,0,0,0,0,   0,0,  3, 0,3, 3,  0,0);
    ds("fill4",           1, 1,0,0,0,0,   0,0,  4, 0,4, 4,  0,0);
    ds("fill5",           1, 1,0,0,0,0,   0,0,  5, 0,0, 5,  0,0);
    ds("ovf_with_errclr", 1, 1,0,0,0,1,   1,0,  5, 0,0, 5,  1,0);
    ds("err_clr3",        1, 0,0,0,0,1,   0,0,  5, 0,0, 5,  0,0);
    ds("clear_full_wr_rd",1, 1,1,1,0,0,   1,0,  0, 0,0, 5,  1,0);
    step("thr_live",      1, 0,0,0,0,0, 0,1,  0,0,  0, 0,0, 5,  1,0);
    ds("wm_and_err_clr",  1, 0,0,0,1,1,   0,0,  0, 0,0, 0,  0,0);

    mu = 0; mr = 0; mw = 0; mh = 0; mo = 0; mun = 0;
    for (int i = 0; i < 3000; i++) begin
      bit w, r, c, wm, ec, heavy, fl, em, wa, ra, eo, eu;
      int aft, aet;
      heavy = ((i / 150) % 2) == 0;
      w  = $urandom_range(0, 99) < (heavy ? 75 : 30);
      r  = $urandom_range(0, 99) < (heavy ? 30 : 75);
      c  = $urandom_range(0, 99) < 2;
      wm = $urandom_range(0, 99) < 3;
      ec = $urandom_range(0, 99) < 5;
      aft = $urandom_range(0, 6);
      aet = $urandom_range(0, 6);
      fl = (mu == D);
      em = (mu == 0);
      wa = w && !fl && !c;
      ra = r && !em && !c;
      eo = w && fl;
      eu = r && em;
      if (c) begin
        mu = 0; mr = 0; mw = 0;
      end else begin
        mu = mu + int'(wa) - int'(ra);
        if (ra) mr = (mr + 1) % D;
        if (wa) mw = (mw + 1) % D;
      end
      mh  = wm ? mu : ((mu > mh) ? mu : mh);
      mo  = eo ? 1'b1 : (ec ? 1'b0 : mo);
      mun = eu ? 1'b1 : (ec ? 1'b0 : mun);
      step("rand", 1, w, r, c, wm, ec, aft, aet, eo, eu, mu, mr, mw, mh, mo, mun);
    end

    @(negedge clk);
    wen = 0; ren = 0; clear = 0; wm_clr = 0; err_clr = 0;
    for (int i = 0; i < 50 && (q.size() != 0 || busy); i++) @(posedge clk);
    #2;
    chk("end", "queue_drained", q.size(), 0);
    chk("end", "cov_used_zero", int'(seen_zero), 1);
    chk("end", "cov_used_full", int'(seen_full), 1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
